// File: rtl/matrix_ls_sequencer.sv
// rtl/matrix_ls_sequencer.sv - row sequencer for matrix load (ld.m) and store (st.m) ops
module matrix_ls_sequencer #(
  parameter int DIM      = 4,
  parameter int ELEM_W   = 16,
  parameter int ADDR_W   = 32,
  parameter int MAT_REGS = 16,
  parameter int MAX_OUT  = 2,
  parameter int RW       = DIM * ELEM_W,
  parameter int MR_W     = (MAT_REGS > 1) ? $clog2(MAT_REGS) : 1,
  parameter int ROW_W    = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [3:0]        req_stride,
  input  logic [MR_W-1:0]   req_mreg,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [RW-1:0]     mem_wdata,
  input  logic              mem_rvalid,
  input  logic [RW-1:0]     mem_rdata,
  output logic [MR_W-1:0]   rf_rd_reg,
  output logic [ROW_W-1:0]  rf_rd_row,
  input  logic [RW-1:0]     rf_rd_data,
  output logic              rf_wr_en,
  output logic [MR_W-1:0]   rf_wr_reg,
  output logic [ROW_W-1:0]  rf_wr_row,
  output logic [RW-1:0]     rf_wr_data,
  output logic              busy,
  output logic              done
);

  // Counters must hold the value DIM (all rows issued / all responses seen).
  localparam int CW = $clog2(DIM + 1);
  localparam int OW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  stride_q, stride_d;
  logic [MR_W-1:0]    mreg_q, mreg_d;
  logic               is_store_q, is_store_d;
  logic [CW-1:0]      issue_row_q, issue_row_d;
  logic [CW-1:0]      resp_cnt_q, resp_cnt_d;
  logic [OW-1:0]      outst_q, outst_d;
  logic               done_q, done_d;
  logic               rf_wr_en_q, rf_wr_en_d;
  logic [MR_W-1:0]    rf_wr_reg_q, rf_wr_reg_d;
  logic [ROW_W-1:0]   rf_wr_row_q, rf_wr_row_d;
  logic [RW-1:0]      rf_wr_data_q, rf_wr_data_d;

  logic               issue_ok;
  logic               issue_fire;
  logic               load_fire;
  logic               resp_hit;
  logic               last_row;
  logic [ADDR_W-1:0]  req_row_stride;
  logic [ADDR_W-1:0]  row_off;

  // State and datapath registers; reset abandons any op and zeroes every counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      base_q       <= '0;
      stride_q     <= '0;
      mreg_q       <= '0;
      is_store_q   <= 1'b0;
      issue_row_q  <= '0;
      resp_cnt_q   <= '0;
      outst_q      <= '0;
      done_q       <= 1'b0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_reg_q  <= '0;
      rf_wr_row_q  <= '0;
      rf_wr_data_q <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      stride_q     <= stride_d;
      mreg_q       <= mreg_d;
      is_store_q   <= is_store_d;
      issue_row_q  <= issue_row_d;
      resp_cnt_q   <= resp_cnt_d;
      outst_q      <= outst_d;
      done_q       <= done_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_reg_q  <= rf_wr_reg_d;
      rf_wr_row_q  <= rf_wr_row_d;
      rf_wr_data_q <= rf_wr_data_d;
    end
  end

  // Handshake qualifiers: loads need a free credit, judged on the registered count only.
  always_comb begin
    req_row_stride = (req_stride == 4'd0) ? ADDR_W'(RW / 8) : ADDR_W'({req_stride, 2'b00});
    issue_ok   = (state_q == ISSUE) && (issue_row_q < CW'(DIM)) &&
                 (is_store_q || (outst_q < OW'(MAX_OUT)));
    issue_fire = issue_ok && mem_ready;
    load_fire  = issue_fire && !is_store_q;
    resp_hit   = mem_rvalid && (outst_q != '0);
    last_row   = (issue_row_q == CW'(DIM - 1));
  end

  // Next-state, counter and response-capture logic.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    stride_d     = stride_q;
    mreg_d       = mreg_q;
    is_store_d   = is_store_q;
    issue_row_d  = issue_row_q + CW'(issue_fire);
    resp_cnt_d   = resp_cnt_q + CW'(resp_hit);
    outst_d      = outst_q + OW'(load_fire) - OW'(resp_hit);
    done_d       = 1'b0;
    rf_wr_en_d   = 1'b0;
    rf_wr_reg_d  = rf_wr_reg_q;
    rf_wr_row_d  = rf_wr_row_q;
    rf_wr_data_d = rf_wr_data_q;

    // A counted response is written to the RF on the following cycle.
    if (resp_hit) begin
      rf_wr_en_d   = 1'b1;
      rf_wr_reg_d  = mreg_q;
      rf_wr_row_d  = resp_cnt_q[ROW_W-1:0];
      rf_wr_data_d = mem_rdata;
    end

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d      = req_base;
          stride_d    = req_row_stride;
          mreg_d      = req_mreg;
          is_store_d  = req_is_store;
          issue_row_d = '0;
          resp_cnt_d  = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_fire && last_row) begin
          if (is_store_q || (outst_d == '0)) begin
            state_d     = IDLE;
            done_d      = 1'b1;
            issue_row_d = '0;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Finishing on the next count makes done coincide with the final RF write.
        if (resp_cnt_d == CW'(DIM)) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          issue_row_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request port: address and data derive from registers only, so they hold during stalls.
  always_comb begin
    row_off   = ADDR_W'(issue_row_q) * stride_q;
    mem_valid = issue_ok;
    mem_wen   = issue_ok && is_store_q;
    mem_addr  = issue_ok ? (base_q + row_off) : '0;
    mem_wdata = (issue_ok && is_store_q) ? rf_rd_data : '0;
    rf_rd_reg = mreg_q;
    rf_rd_row = issue_row_q[ROW_W-1:0];
  end

  // Status and RF write outputs.
  always_comb begin
    req_ready  = (state_q == IDLE);
    busy       = (state_q != IDLE);
    done       = done_q;
    rf_wr_en   = rf_wr_en_q;
    rf_wr_reg  = rf_wr_reg_q;
    rf_wr_row  = rf_wr_row_q;
    rf_wr_data = rf_wr_data_q;
  end

endmodule

// File: tb/tb_matrix_ls_sequencer.sv
// tb/tb_matrix_ls_sequencer.sv - directed bench for matrix_ls_sequencer
module tb_matrix_ls_sequencer;

  typedef struct { int cyc; logic [31:0] addr; logic wen; logic [63:0] wdata; } req_t;
  typedef struct { int cyc; logic [3:0] rg; logic [1:0] row; logic [63:0] data; } wr_t;
  typedef struct { int due; logic [63:0] data; } resp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready, req_is_store;
  logic [31:0] req_base;
  logic [3:0]  req_stride, req_mreg;
  logic        mem_valid, mem_ready, mem_wen;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic [3:0]  rf_rd_reg;
  logic [1:0]  rf_rd_row;
  logic [63:0] rf_rd_data;
  logic        rf_wr_en;
  logic [3:0]  rf_wr_reg;
  logic [1:0]  rf_wr_row;
  logic [63:0] rf_wr_data;
  logic        busy, done;

  logic [63:0] rf_mem [16][4];
  req_t  req_log[$];
  wr_t   wr_log[$];
  int    done_log[$];
  int    vld_log[$];
  resp_t resp_q[$];

  int cyc = 0;
  int lat = 1;
  int bench_out = 0;
  int max_out = 0;
  int checks = 0;
  int passed = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  assign rf_rd_data = rf_mem[rf_rd_reg][rf_rd_row];

  matrix_ls_sequencer dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_base(req_base), .req_stride(req_stride), .req_mreg(req_mreg),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_rd_reg(rf_rd_reg), .rf_rd_row(rf_rd_row), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_row(rf_wr_row), .rf_wr_data(rf_wr_data),
    .busy(busy), .done(done)
  );

  function automatic logic [63:0] rdat(input logic [31:0] a);
    return {a ^ 32'h5A5A_C3C3, ~a};
  endfunction

  // Observe every cycle mid-period; queue load responses at the current latency.
  initial begin
    forever begin
      @(negedge CLK);
      if (mem_valid) vld_log.push_back(cyc);
      if (mem_valid && mem_ready) begin
        req_log.push_back('{cyc, mem_addr, mem_wen, mem_wdata});
        if (!mem_wen) resp_q.push_back('{cyc + lat, rdat(mem_addr)});
      end
      if (rf_wr_en) wr_log.push_back('{cyc, rf_wr_reg, rf_wr_row, rf_wr_data});
      if (done) done_log.push_back(cyc);
      if (RST) bench_out = 0;
      else begin
        if (mem_rvalid && bench_out > 0) bench_out = bench_out - 1;
        if (mem_valid && mem_ready && !mem_wen) bench_out = bench_out + 1;
      end
      if (bench_out > max_out) max_out = bench_out;
    end
  end

  // In-order memory responder.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = resp_q[0].data;
        void'(resp_q.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
    end
  end

  task automatic clear_logs();
    req_log.delete(); wr_log.delete(); done_log.delete(); vld_log.delete();
    max_out = 0;
  endtask

  task automatic issue_op(input logic st, input logic [31:0] base, input logic [3:0] stride,
                          input logic [3:0] mreg, output int t);
    int n;
    @(posedge CLK); #1;
    req_valid = 1'b1; req_is_store = st; req_base = base; req_stride = stride; req_mreg = mreg;
    @(negedge CLK);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    t = cyc;
    checks++;
    if (req_ready !== 1'b1) $display("FAIL accept: req_ready=%b want 1", req_ready);
    else passed++;
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", req_ready); else passed++;
    checks++;
    if ({mem_valid, mem_wen, rf_wr_en, busy, done} !== 5'b0)
      $display("FAIL rst_flags: got %b want 00000", {mem_valid, mem_wen, rf_wr_en, busy, done});
    else passed++;
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 64'h0)
      $display("FAIL rst_mem: addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    else passed++;
    checks++;
    if ({rf_wr_reg, rf_wr_row, rf_wr_data, rf_rd_reg, rf_rd_row} !== '0)
      $display("FAIL rst_rf: wr=%h/%h/%h rd=%h/%h want 0", rf_wr_reg, rf_wr_row, rf_wr_data, rf_rd_reg, rf_rd_row);
    else passed++;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_packed_load();
    int t;
    logic [31:0] ea;
    clear_logs(); lat = 1; mem_ready = 1'b1;
    issue_op(1'b0, 32'h1000, 4'd0, 4'd5, t);
    repeat (8) @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) begin
      ea = 32'h1000 + 32'(8 * i);
      checks++;
      if (i >= req_log.size()) $display("FAIL pl_req%0d: got none want addr %h", i, ea);
      else if (req_log[i].addr !== ea || req_log[i].wen !== 1'b0 || req_log[i].cyc != t + 1 + i)
        $display("FAIL pl_req%0d: got addr %h wen %b cyc %0d want %h 0 %0d", i,
                 req_log[i].addr, req_log[i].wen, req_log[i].cyc, ea, t + 1 + i);
      else passed++;
      checks++;
      if (i >= wr_log.size()) $display("FAIL pl_wr%0d: got none want row %0d", i, i);
      else if (wr_log[i].rg !== 4'd5 || wr_log[i].row !== 2'(i) || wr_log[i].data !== rdat(ea) ||
               wr_log[i].cyc != t + 3 + i)
        $display("FAIL pl_wr%0d: got reg %0d row %0d data %h cyc %0d want 5 %0d %h %0d", i,
                 wr_log[i].rg, wr_log[i].row, wr_log[i].data, wr_log[i].cyc, i, rdat(ea), t + 3 + i);
      else passed++;
    end
    checks++;
    if (done_log.size() != 1 || done_log[0] != t + 6)
      $display("FAIL pl_done: got %0d pulses first %0d want 1 at %0d", done_log.size(),
               (done_log.size() > 0) ? done_log[0] : -1, t + 6);
    else passed++;
  endtask

  task automatic test_strided_store();
    int t;
    logic [31:0] ea;
    clear_logs(); mem_ready = 1'b1;
    issue_op(1'b1, 32'h2000, 4'd3, 4'd3, t);
    repeat (6) @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) begin
      ea = 32'h2000 + 32'(12 * i);
      checks++;
      if (i >= req_log.size()) $display("FAIL ss_req%0d: got none want addr %h", i, ea);
      else if (req_log[i].addr !== ea || req_log[i].wen !== 1'b1 ||
               req_log[i].wdata !== rf_mem[3][i] || req_log[i].cyc != t + 1 + i)
        $display("FAIL ss_req%0d: got %h %b %h cyc %0d want %h 1 %h %0d", i, req_log[i].addr,
                 req_log[i].wen, req_log[i].wdata, req_log[i].cyc, ea, rf_mem[3][i], t + 1 + i);
      else passed++;
    end
    checks++;
    if (done_log.size() != 1 || done_log[0] != t + 5 || wr_log.size() != 0)
      $display("FAIL ss_done: got %0d pulses first %0d rfwr %0d want 1 at %0d rfwr 0", done_log.size(),
               (done_log.size() > 0) ? done_log[0] : -1, wr_log.size(), t + 5);
    else passed++;
  endtask

  task automatic test_backpressure();
    int t;
    int k;
    logic [31:0] ea;
    clear_logs();
    issue_op(1'b1, 32'h3000, 4'd1, 4'd3, t);
    for (int n = 0; n < 10; n++) begin
      k = cyc - t;
      mem_ready = !(k >= 3 && k <= 5);
      @(negedge CLK);
      if (k >= 3 && k <= 5) begin
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h3008 || mem_wdata !== rf_mem[3][2] || mem_wen !== 1'b1)
          $display("FAIL bp_stall%0d: got v%b a%h d%h w%b want v1 a00003008 d%h w1", k,
                   mem_valid, mem_addr, mem_wdata, mem_wen, rf_mem[3][2]);
        else passed++;
      end
      @(posedge CLK); #1;
    end
    mem_ready = 1'b1;
    checks++;
    if (req_log.size() != 4) $display("FAIL bp_count: got %0d rows want 4", req_log.size());
    else passed++;
    for (int i = 0; i < 4 && i < req_log.size(); i++) begin
      ea = 32'h3000 + 32'(4 * i);
      checks++;
      if (req_log[i].addr !== ea || req_log[i].wdata !== rf_mem[3][i])
        $display("FAIL bp_row%0d: got %h %h want %h %h", i, req_log[i].addr, req_log[i].wdata, ea, rf_mem[3][i]);
      else passed++;
    end
    checks++;
    if (done_log.size() != 1 || done_log[0] != t + 8)
      $display("FAIL bp_done: got %0d pulses first %0d want 1 at %0d", done_log.size(),
               (done_log.size() > 0) ? done_log[0] : -1, t + 8);
    else passed++;
  endtask

  task automatic test_credit_throttle();
    int t;
    int ev[4];
    int ew[4];
    clear_logs(); lat = 4; mem_ready = 1'b1;
    issue_op(1'b0, 32'h4000, 4'd4, 4'd7, t);
    repeat (14) @(posedge CLK); #1;
    ev = '{t + 1, t + 2, t + 6, t + 7};
    ew = '{t + 6, t + 7, t + 11, t + 12};
    checks++;
    if (max_out > 2) $display("FAIL ct_outstanding: got max %0d want <= 2", max_out); else passed++;
    checks++;
    if (vld_log.size() != 4) $display("FAIL ct_valid_cycles: got %0d valid cycles want 4", vld_log.size());
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= vld_log.size() || vld_log[i] != ev[i])
        $display("FAIL ct_valid%0d: got cyc %0d want %0d", i, (i < vld_log.size()) ? vld_log[i] : -1, ev[i]);
      else passed++;
      checks++;
      if (i >= wr_log.size()) $display("FAIL ct_wr%0d: got none want cyc %0d", i, ew[i]);
      else if (wr_log[i].rg !== 4'd7 || wr_log[i].row !== 2'(i) || wr_log[i].cyc != ew[i] ||
               wr_log[i].data !== rdat(32'h4000 + 32'(16 * i)))
        $display("FAIL ct_wr%0d: got reg %0d row %0d cyc %0d data %h want 7 %0d %0d %h", i, wr_log[i].rg,
                 wr_log[i].row, wr_log[i].cyc, wr_log[i].data, i, ew[i], rdat(32'h4000 + 32'(16 * i)));
      else passed++;
    end
    checks++;
    if (done_log.size() != 1 || done_log[0] != t + 12)
      $display("FAIL ct_done: got %0d pulses first %0d want 1 at %0d", done_log.size(),
               (done_log.size() > 0) ? done_log[0] : -1, t + 12);
    else passed++;
  endtask

  task automatic test_wrap_stray();
    int t;
    logic [31:0] ea[4];
    clear_logs(); lat = 1; mem_ready = 1'b1;
    resp_q.push_back('{cyc + 1, 64'hDEAD_BEEF_0000_0001});
    repeat (4) @(posedge CLK); #1;
    checks++;
    if (wr_log.size() != 0 || busy !== 1'b0)
      $display("FAIL stray: got %0d rf writes busy %b want 0 0", wr_log.size(), busy);
    else passed++;
    ea = '{32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0008, 32'h0000_0010};
    issue_op(1'b0, 32'hFFFF_FFF8, 4'd0, 4'd9, t);
    repeat (8) @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= req_log.size()) $display("FAIL wr_req%0d: got none want %h", i, ea[i]);
      else if (req_log[i].addr !== ea[i]) $display("FAIL wr_req%0d: got %h want %h", i, req_log[i].addr, ea[i]);
      else passed++;
    end
    checks++;
    if (wr_log.size() != 4 || done_log.size() != 1 || wr_log[3].data !== rdat(32'h10) || wr_log[3].rg !== 4'd9)
      $display("FAIL wr_result: got %0d rf writes %0d done want 4 1", wr_log.size(), done_log.size());
    else passed++;
  endtask

  task automatic test_reset_mid_load();
    int t;
    clear_logs(); lat = 6; mem_ready = 1'b1;
    issue_op(1'b0, 32'h5000, 4'd0, 4'd2, t);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (req_ready !== 1'b1 || {mem_valid, mem_wen, rf_wr_en, busy, done} !== 5'b0 || mem_addr !== 32'h0)
      $display("FAIL rm_outputs: got rdy %b flags %b addr %h want 1 00000 0", req_ready,
               {mem_valid, mem_wen, rf_wr_en, busy, done}, mem_addr);
    else passed++;
    checks++;
    if (req_log.size() != 2) $display("FAIL rm_issued: got %0d rows want 2", req_log.size()); else passed++;
    repeat (8) @(posedge CLK); #1;
    checks++;
    if (wr_log.size() != 0 || done_log.size() != 0)
      $display("FAIL rm_late: got %0d rf writes %0d done want 0 0", wr_log.size(), done_log.size());
    else passed++;
    clear_logs();
    issue_op(1'b1, 32'h6000, 4'd0, 4'd3, t);
    repeat (6) @(posedge CLK); #1;
    checks++;
    if (req_log.size() != 4 || req_log[3].addr !== 32'h6018 || req_log[3].wdata !== rf_mem[3][3])
      $display("FAIL rm_next: got %0d rows last %h want 4 rows last 00006018",
               req_log.size(), (req_log.size() > 0) ? req_log[req_log.size() - 1].addr : 32'h0);
    else passed++;
    checks++;
    if (done_log.size() != 1 || done_log[0] != t + 5)
      $display("FAIL rm_next_done: got %0d pulses first %0d want 1 at %0d", done_log.size(),
               (done_log.size() > 0) ? done_log[0] : -1, t + 5);
    else passed++;
  endtask

  initial begin
    RST = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_base = '0; req_stride = '0; req_mreg = '0;
    mem_ready = 1'b1;
    for (int r = 0; r < 16; r++)
      for (int i = 0; i < 4; i++)
        rf_mem[r][i] = {16'(r), 16'(i), 32'hC0DE_0000 + 32'(r * 4 + i)};
    test_reset();
    test_packed_load();
    test_strided_store();
    test_backpressure();
    test_credit_throttle();
    test_wrap_stray();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
